// File: rtl/mult_pipe_pkg.sv
// Shared types and limits for the MULT writeback pipeline.
package mult_pipe_pkg;

   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned REG_BITS    = 5;
   localparam int unsigned MAX_LATENCY = 8;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [REG_BITS-1:0]   rd;
      logic                  regwrite;
   } mult_entry_t;

endpackage

// File: rtl/mult_writeback_pipe_if.sv
// Issue/execute-side and writeback-side signals of the MULT result pipeline.
interface mult_writeback_pipe_if
   import mult_pipe_pkg::*;
#(
   parameter int unsigned LATENCY = 2
);

   localparam int unsigned CountBits = $clog2(LATENCY + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_result;
   logic [REG_BITS-1:0]   in_rd;
   logic                  in_regwrite;
   logic                  flush;
   logic                  wb_valid;
   logic                  wb_grant;
   logic [DATA_WIDTH-1:0] wb_result;
   logic [REG_BITS-1:0]   wb_rd;
   logic                  wb_regwrite;
   logic [REG_BITS-1:0]   hazard_rd;
   logic                  hazard_hit;
   logic [CountBits-1:0]  pending_count;

   modport master (
      output in_valid, in_result, in_rd, in_regwrite, flush, wb_grant, hazard_rd,
      input  in_ready, wb_valid, wb_result, wb_rd, wb_regwrite, hazard_hit, pending_count
   );

   modport slave (
      input  in_valid, in_result, in_rd, in_regwrite, flush, wb_grant, hazard_rd,
      output in_ready, wb_valid, wb_result, wb_rd, wb_regwrite, hazard_hit, pending_count
   );

endinterface

// File: rtl/mult_pipe_slot.sv
// One pipeline slot: valid bit plus entry, loaded on enable, valid killed by clear.
module mult_pipe_slot
   import mult_pipe_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic        valid_in,
   input  mult_entry_t entry_in,
   output logic        valid,
   output mult_entry_t entry
);

   logic        valid_q;
   mult_entry_t entry_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else begin
         if (clear) begin
            valid_q <= 1'b0;
         end else if (load) begin
            valid_q <= valid_in;
         end
         if (load) begin
            entry_q <= entry_in;
         end
      end
   end

   assign valid = valid_q;
   assign entry = entry_q;

endmodule

// File: rtl/mult_writeback_pipe.sv
// In-order MULT result pipeline with back-pressure, bubble collapse, flush and rd-hazard query.
module mult_writeback_pipe
   import mult_pipe_pkg::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input logic                  clock,
   input logic                  reset,
   mult_writeback_pipe_if.slave bus
);

   localparam int unsigned CountBits = $clog2(LATENCY + 1);

   if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("mult_writeback_pipe: LATENCY must be in 1..MAX_LATENCY");
   end

   logic [LATENCY-1:0]   valid;
   logic [LATENCY-1:0]   valid_in;
   logic [LATENCY-1:0]   adv;
   mult_entry_t          entry    [LATENCY];
   mult_entry_t          entry_in [LATENCY];
   logic                 accept;
   logic                 commit;
   logic                 hit;
   logic [CountBits-1:0] count_q;
   logic [CountBits-1:0] count_d;

   // A stage may advance when it is empty or everything downstream of it moves.
   always_comb begin
      adv = '0;
      adv[LATENCY-1] = !valid[LATENCY-1] || bus.wb_grant;
      for (int unsigned j = 1; j < LATENCY; j++) begin
         adv[LATENCY-1-j] = !valid[LATENCY-1-j] || adv[LATENCY-j];
      end
   end

   assign bus.in_ready = adv[0] && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;
   assign commit       = valid[LATENCY-1] && bus.wb_grant && !bus.flush;

   // x0 writes are dropped at entry so the output and hazard paths never see them.
   always_comb begin
      valid_in[0]          = accept;
      entry_in[0].result   = bus.in_result;
      entry_in[0].rd       = bus.in_rd;
      entry_in[0].regwrite = bus.in_regwrite && (bus.in_rd != '0);
      for (int unsigned i = 1; i < LATENCY; i++) begin
         valid_in[i] = valid[i-1];
         entry_in[i] = entry[i-1];
      end
   end

   for (genvar i = 0; i < LATENCY; i++) begin : g_slot
      mult_pipe_slot u_slot (
         .clock    (clock),
         .reset    (reset),
         .load     (adv[i]),
         .clear    (bus.flush),
         .valid_in (valid_in[i]),
         .entry_in (entry_in[i]),
         .valid    (valid[i]),
         .entry    (entry[i])
      );
   end

   always_comb begin
      if (bus.flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CountBits'(accept) - CountBits'(commit);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         if (valid[i] && entry[i].regwrite && (entry[i].rd == bus.hazard_rd)) begin
            hit = 1'b1;
         end
      end
   end

   assign bus.hazard_hit    = hit && (bus.hazard_rd != '0);
   assign bus.pending_count = count_q;
   assign bus.wb_valid      = valid[LATENCY-1] && !bus.flush;
   assign bus.wb_result     = entry[LATENCY-1].result;
   assign bus.wb_rd         = entry[LATENCY-1].rd;
   assign bus.wb_regwrite   = entry[LATENCY-1].regwrite;

endmodule

// File: tb/tb_mult_writeback_pipe.sv
// Directed and randomised checks of mult_writeback_pipe at LATENCY 1, 2, 3, 4 and 8.
module tb_mult_writeback_pipe;
   import mult_pipe_pkg::*;

   localparam int NDut = 5;
   localparam int D2   = 1;
   localparam int D3   = 2;

   function automatic int unsigned lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 2;
         2:       return 3;
         3:       return 4;
         default: return 8;
      endcase
   endfunction

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_result;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        flush;
   logic        wb_grant;
   logic [4:0]  hazard_rd;

   logic        in_ready_a    [NDut];
   logic        wb_valid_a    [NDut];
   logic [31:0] wb_result_a   [NDut];
   logic [4:0]  wb_rd_a       [NDut];
   logic        wb_regwrite_a [NDut];
   logic        hazard_hit_a  [NDut];
   logic [3:0]  pend_a        [NDut];

   int vectors     = 0;
   int miscompares = 0;

   exp_t sb [NDut][16];
   int   head [NDut];
   int   cnt  [NDut];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   for (genvar k = 0; k < NDut; k++) begin : g_dut
      localparam int unsigned L = lat_of(k);
      mult_writeback_pipe_if #(.LATENCY(L)) bus ();
      assign bus.in_valid    = in_valid;
      assign bus.in_result   = in_result;
      assign bus.in_rd       = in_rd;
      assign bus.in_regwrite = in_regwrite;
      assign bus.flush       = flush;
      assign bus.wb_grant    = wb_grant;
      assign bus.hazard_rd   = hazard_rd;
      assign in_ready_a[k]    = bus.in_ready;
      assign wb_valid_a[k]    = bus.wb_valid;
      assign wb_result_a[k]   = bus.wb_result;
      assign wb_rd_a[k]       = bus.wb_rd;
      assign wb_regwrite_a[k] = bus.wb_regwrite;
      assign hazard_hit_a[k]  = bus.hazard_hit;
      assign pend_a[k]        = 4'(bus.pending_count);
      mult_writeback_pipe #(.LATENCY(L)) dut (
         .clock (clock),
         .reset (reset),
         .bus   (bus)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid    = 1'b0;
      in_result   = '0;
      in_rd       = '0;
      in_regwrite = 1'b0;
      flush       = 1'b0;
      wb_grant    = 1'b0;
      hazard_rd   = '0;
   endtask

   task automatic send(input logic [31:0] r, input logic [4:0] d, input logic w);
      in_valid    = 1'b1;
      in_result   = r;
      in_rd       = d;
      in_regwrite = w;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      exp_t        e;
      logic        exp_hit;
      logic        exp_rdy;
      int unsigned lat;
      int          peak;
      int          exp_pend;

      reset = 1'b1;
      idle_inputs();
      hazard_rd = 5'd5;

      // 1: reset state, mid-stream reset, latency at L=2
      repeat (2) next_cycle();
      #1;
      chk("t1_rst_wb_valid", wb_valid_a[D2], 0);
      chk("t1_rst_wb_result", wb_result_a[D2], 0);
      chk("t1_rst_wb_rd", wb_rd_a[D2], 0);
      chk("t1_rst_wb_regwrite", wb_regwrite_a[D2], 0);
      chk("t1_rst_pending", 32'(pend_a[D2]), 0);
      chk("t1_rst_hazard", hazard_hit_a[D2], 0);
      next_cycle();
      reset = 1'b0;
      send(32'hAAAA, 5'd3, 1'b1);
      #1;
      chk("t1_ready_after_release", in_ready_a[D2], 1);
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("t1_pre_pending", 32'(pend_a[D2]), 1);
      chk("t1_pre_wb_valid", wb_valid_a[D2], 0);
      next_cycle();
      #1;
      chk("t1_pre_out_valid", wb_valid_a[D2], 1);
      chk("t1_pre_out_result", wb_result_a[D2], 32'hAAAA);
      reset = 1'b1;
      #1;
      chk("t1_midrst_wb_valid", wb_valid_a[D2], 0);
      chk("t1_midrst_pending", 32'(pend_a[D2]), 0);
      chk("t1_midrst_result", wb_result_a[D2], 0);
      next_cycle();
      reset = 1'b0;
      send(32'h1234, 5'd5, 1'b1);
      wb_grant = 1'b1;
      #1;
      chk("t1_in_ready", in_ready_a[D2], 1);
      chk("t1_wb_idle", wb_valid_a[D2], 0);
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("t1_lat_wb_valid0", wb_valid_a[D2], 0);
      chk("t1_lat_pending", 32'(pend_a[D2]), 1);
      next_cycle();
      #1;
      chk("t1_out_valid", wb_valid_a[D2], 1);
      chk("t1_out_result", wb_result_a[D2], 32'h1234);
      chk("t1_out_rd", wb_rd_a[D2], 5);
      chk("t1_out_regwrite", wb_regwrite_a[D2], 1);
      next_cycle();
      #1;
      chk("t1_drained_valid", wb_valid_a[D2], 0);
      chk("t1_drained_pending", 32'(pend_a[D2]), 0);

      // 2: back-to-back at L=3; item k appears in cycle k+3
      next_cycle();
      idle_inputs();
      pulse_reset();
      peak = 0;
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         in_valid  = (k <= 6);
         in_result = 32'(k);
         in_rd     = 5'(k);
         in_regwrite = 1'b1;
         wb_grant  = 1'b1;
         #1;
         exp_pend = ((k - 1 < 6) ? k - 1 : 6) - ((k - 4 > 0) ? k - 4 : 0);
         chk("t2_pending", 32'(pend_a[D3]), 32'(exp_pend));
         chk("t2_wb_valid", wb_valid_a[D3], (k >= 4 && k <= 9));
         if (k >= 4 && k <= 9) chk("t2_wb_result", wb_result_a[D3], 32'(k - 3));
         if (k <= 6) chk("t2_in_ready", in_ready_a[D3], 1);
         if (int'(pend_a[D3]) > peak) peak = int'(pend_a[D3]);
      end
      chk("t2_peak", 32'(peak), 3);

      // 3: stall with bubble collapse at L=3
      next_cycle();
      idle_inputs();
      pulse_reset();
      next_cycle();
      send(32'hA0, 5'd1, 1'b1);
      #1;
      chk("t3_c1_ready", in_ready_a[D3], 1);
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("t3_c2_pending", 32'(pend_a[D3]), 1);
      next_cycle();
      send(32'hB0, 5'd2, 1'b1);
      #1;
      chk("t3_c3_ready", in_ready_a[D3], 1);
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("t3_c4_wb_valid", wb_valid_a[D3], 1);
      chk("t3_c4_result", wb_result_a[D3], 32'hA0);
      chk("t3_c4_pending", 32'(pend_a[D3]), 2);
      next_cycle();
      send(32'hC0, 5'd3, 1'b1);
      #1;
      chk("t3_c5_hold_result", wb_result_a[D3], 32'hA0);
      chk("t3_c5_pending", 32'(pend_a[D3]), 2);
      chk("t3_c5_ready", in_ready_a[D3], 1);
      next_cycle();
      send(32'hD0, 5'd4, 1'b1);
      #1;
      chk("t3_c6_pending", 32'(pend_a[D3]), 3);
      chk("t3_c6_full_ready", in_ready_a[D3], 0);
      chk("t3_c6_hold_result", wb_result_a[D3], 32'hA0);
      next_cycle();
      in_valid = 1'b0;
      wb_grant = 1'b1;
      #1;
      chk("t3_c7_result", wb_result_a[D3], 32'hA0);
      chk("t3_c7_ready_grant", in_ready_a[D3], 1);
      chk("t3_c7_pending", 32'(pend_a[D3]), 3);
      next_cycle();
      #1;
      chk("t3_c8_valid", wb_valid_a[D3], 1);
      chk("t3_c8_result", wb_result_a[D3], 32'hB0);
      chk("t3_c8_pending", 32'(pend_a[D3]), 2);
      next_cycle();
      #1;
      chk("t3_c9_result", wb_result_a[D3], 32'hC0);
      chk("t3_c9_pending", 32'(pend_a[D3]), 1);
      next_cycle();
      #1;
      chk("t3_c10_valid", wb_valid_a[D3], 0);
      chk("t3_c10_pending", 32'(pend_a[D3]), 0);

      // 4: flush with three entries in flight at L=3
      next_cycle();
      idle_inputs();
      pulse_reset();
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         send(32'(k), 5'(k), 1'b1);
      end
      next_cycle();
      send(32'h99, 5'd9, 1'b1);
      flush    = 1'b1;
      wb_grant = 1'b1;
      #1;
      chk("t4_pending_before", 32'(pend_a[D3]), 3);
      chk("t4_flush_wb_valid", wb_valid_a[D3], 0);
      chk("t4_flush_in_ready", in_ready_a[D3], 0);
      next_cycle();
      idle_inputs();
      wb_grant = 1'b1;
      #1;
      chk("t4_pending_after", 32'(pend_a[D3]), 0);
      repeat (4) begin
         next_cycle();
         #1;
         chk("t4_nothing_emerges", wb_valid_a[D3], 0);
      end

      // 5: hazard query and x0 suppression at L=3
      next_cycle();
      idle_inputs();
      pulse_reset();
      next_cycle();
      send(32'h70, 5'd7, 1'b1);
      next_cycle();
      send(32'h05, 5'd0, 1'b1);
      next_cycle();
      in_valid  = 1'b0;
      hazard_rd = 5'd7;
      #1;
      chk("t5_hit_rd7", hazard_hit_a[D3], 1);
      hazard_rd = 5'd0;
      #1;
      chk("t5_hit_rd0", hazard_hit_a[D3], 0);
      hazard_rd = 5'd3;
      #1;
      chk("t5_hit_rd3", hazard_hit_a[D3], 0);
      send(32'h90, 5'd9, 1'b1);
      hazard_rd = 5'd9;
      #1;
      chk("t5_input_excluded", hazard_hit_a[D3], 0);
      in_valid = 1'b0;
      next_cycle();
      hazard_rd = 5'd7;
      wb_grant  = 1'b1;
      #1;
      chk("t5_out7_valid", wb_valid_a[D3], 1);
      chk("t5_out7_rd", wb_rd_a[D3], 7);
      chk("t5_out7_regwrite", wb_regwrite_a[D3], 1);
      chk("t5_out7_hit", hazard_hit_a[D3], 1);
      next_cycle();
      #1;
      chk("t5_out0_valid", wb_valid_a[D3], 1);
      chk("t5_out0_rd", wb_rd_a[D3], 0);
      chk("t5_out0_regwrite", wb_regwrite_a[D3], 0);
      chk("t5_out0_result", wb_result_a[D3], 32'h05);
      chk("t5_hit_after_exit", hazard_hit_a[D3], 0);
      next_cycle();
      #1;
      chk("t5_empty_valid", wb_valid_a[D3], 0);
      chk("t5_empty_pending", 32'(pend_a[D3]), 0);

      // 6: random traffic on every latency against a per-DUT FIFO scoreboard
      next_cycle();
      idle_inputs();
      pulse_reset();
      for (int k = 0; k < NDut; k++) begin
         head[k] = 0;
         cnt[k]  = 0;
      end
      for (int c = 0; c < 420; c++) begin
         next_cycle();
         if (c < 400) begin
            in_valid    = ($urandom_range(0, 9) < 6);
            in_result   = $urandom;
            in_rd       = 5'($urandom_range(0, 31));
            in_regwrite = 1'($urandom_range(0, 1));
            wb_grant    = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 19) == 0);
            hazard_rd   = 5'($urandom_range(0, 31));
         end else begin
            in_valid = 1'b0;
            flush    = 1'b0;
            wb_grant = 1'b1;
         end
         #1;
         for (int k = 0; k < NDut; k++) begin
            lat = lat_of(k);
            chk("rnd_pending", 32'(pend_a[k]), 32'(cnt[k]));
            exp_hit = 1'b0;
            for (int j = 0; j < cnt[k]; j++) begin
               e = sb[k][(head[k] + j) % 16];
               if (e.rw && e.rd == hazard_rd && hazard_rd != 5'd0) exp_hit = 1'b1;
            end
            chk("rnd_hazard", hazard_hit_a[k], exp_hit);
            exp_rdy = !flush && (cnt[k] < int'(lat) || wb_grant);
            chk("rnd_in_ready", in_ready_a[k], exp_rdy);
            if (flush) begin
               chk("rnd_flush_no_wb", wb_valid_a[k], 0);
               cnt[k] = 0;
            end else begin
               if (wb_valid_a[k]) begin
                  chk("rnd_out_nonempty", (cnt[k] != 0), 1);
                  if (cnt[k] != 0) begin
                     e = sb[k][head[k]];
                     chk("rnd_order_result", wb_result_a[k], e.result);
                     chk("rnd_order_rd", wb_rd_a[k], 32'(e.rd));
                     chk("rnd_order_regwrite", wb_regwrite_a[k], e.rw);
                     if (wb_grant) begin
                        head[k] = (head[k] + 1) % 16;
                        cnt[k]--;
                     end
                  end
               end else if (cnt[k] == 0) begin
                  chk("rnd_idle_no_wb", wb_valid_a[k], 0);
               end
               if (in_valid && exp_rdy) begin
                  e.result = in_result;
                  e.rd     = in_rd;
                  e.rw     = in_regwrite && (in_rd != 5'd0);
                  sb[k][(head[k] + cnt[k]) % 16] = e;
                  cnt[k]++;
               end
            end
         end
      end
      next_cycle();
      #1;
      for (int k = 0; k < NDut; k++) begin
         chk("rnd_final_pending", 32'(pend_a[k]), 0);
         chk("rnd_final_wb_valid", wb_valid_a[k], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
